// File: rtl/mvm_pkg.sv
// Shared types and constants for the stochastic MVM job sequencer.
package mvm_pkg;

    localparam int unsigned MVM_LANES = 4;
    localparam int unsigned BN_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_CAPTURE,
        ST_OUT
    } mvm_seq_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_START_TO = 2'd1;
    localparam logic [1:0] ERR_RUN_TO   = 2'd2;

endpackage

// File: rtl/mvm_sat_acc.sv
// Single-lane signed saturating accumulator: adds a sign-extended BN_W-bit
// lane result, clamps at the ACC_W two's-complement limits instead of wrapping.
module mvm_sat_acc
    import mvm_pkg::*;
#(
    parameter int unsigned ACC_W = 8
) (
    input  logic             i_clk_udc,
    input  logic             i_rst_udc,
    input  logic             clr,
    input  logic             add_en,
    input  logic [BN_W-1:0]  din,
    output logic [ACC_W-1:0] acc
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_next;

    // One guard bit is enough: a BN_W-bit addend can overflow by at most one bit.
    assign sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-BN_W){din[BN_W-1]}}, din};

    // Clamp when the guard bit and the result sign disagree.
    always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Accumulator register; clear wins over add.
    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/mvm_job_seq.sv
// Job sequencer for the 4-lane stochastic MVM engine: accepts beats, launches
// the engine, watches busy with timeouts, accumulates lane results and hands
// the sums downstream on the last beat of a job.
module mvm_job_seq
    import mvm_pkg::*;
#(
    parameter int unsigned ACC_W    = 8,
    parameter int unsigned START_TO = 4,
    parameter int unsigned RUN_TO   = 31
) (
    input  logic                         i_clk_udc,
    input  logic                         i_rst_udc,
    input  logic                         i_job_valid,
    output logic                         o_job_ready,
    input  logic [MVM_LANES*BN_W-1:0]    i_job_x,
    input  logic [BN_W-1:0]              i_job_w,
    input  logic                         i_job_last,
    output logic                         o_start_mvm,
    output logic [MVM_LANES*BN_W-1:0]    o_x_mvm,
    output logic [BN_W-1:0]              o_w_mvm,
    input  logic                         i_mvm_busy,
    input  logic [MVM_LANES*BN_W-1:0]    i_wx_result,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic [MVM_LANES*ACC_W-1:0]   o_res_acc,
    output logic                         o_err,
    output logic [1:0]                   o_err_code
);

    localparam int unsigned TO_MAX = (START_TO > RUN_TO) ? START_TO : RUN_TO;
    localparam int unsigned TMR_W  = $clog2(TO_MAX + 1);

    mvm_seq_state_t          state;
    logic [TMR_W-1:0]        timer;
    logic [TMR_W-1:0]        timer_inc;
    logic                    last_q;
    logic                    start_hit;
    logic                    run_hit;
    logic                    acc_clr;
    logic                    acc_add;

    // Timeout detection: abort on the START_TO-th / RUN_TO-th waiting sample.
    assign timer_inc = timer + TMR_W'(1);
    assign start_hit = (state == ST_WAIT_BUSY) && !i_mvm_busy && (timer_inc == TMR_W'(START_TO));
    assign run_hit   = (state == ST_RUN) && i_mvm_busy && (timer_inc == TMR_W'(RUN_TO));

    // Accumulator control: sums are dropped on abort and after hand-off.
    assign acc_clr = start_hit || run_hit || ((state == ST_OUT) && i_res_ready);
    assign acc_add = (state == ST_CAPTURE);

    // Per-lane saturating accumulators.
    for (genvar k = 0; k < MVM_LANES; k++) begin : g_lane
        mvm_sat_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .i_clk_udc (i_clk_udc),
            .i_rst_udc (i_rst_udc),
            .clr       (acc_clr),
            .add_en    (acc_add),
            .din       (i_wx_result[k*BN_W +: BN_W]),
            .acc       (o_res_acc[k*ACC_W +: ACC_W])
        );
    end

    // Sequencer FSM; every output is set for the state being entered.
    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            state       <= ST_IDLE;
            timer       <= '0;
            last_q      <= 1'b0;
            o_job_ready <= 1'b0;
            o_start_mvm <= 1'b0;
            o_x_mvm     <= '0;
            o_w_mvm     <= '0;
            o_res_valid <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= ERR_NONE;
        end else begin
            o_start_mvm <= 1'b0;
            o_err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_job_valid && o_job_ready) begin
                        o_x_mvm     <= i_job_x;
                        o_w_mvm     <= i_job_w;
                        last_q      <= i_job_last;
                        o_job_ready <= 1'b0;
                        o_start_mvm <= 1'b1;
                        state       <= ST_LAUNCH;
                    end else begin
                        o_job_ready <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    timer <= '0;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (i_mvm_busy) begin
                        timer <= '0;
                        state <= ST_RUN;
                    end else if (start_hit) begin
                        timer       <= '0;
                        o_err       <= 1'b1;
                        o_err_code  <= ERR_START_TO;
                        o_job_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_RUN: begin
                    if (!i_mvm_busy) begin
                        state <= ST_CAPTURE;
                    end else if (run_hit) begin
                        timer       <= '0;
                        o_err       <= 1'b1;
                        o_err_code  <= ERR_RUN_TO;
                        o_job_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_CAPTURE: begin
                    if (last_q) begin
                        o_res_valid <= 1'b1;
                        state       <= ST_OUT;
                    end else begin
                        o_job_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        o_job_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    o_res_valid <= 1'b0;
                    o_job_ready <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_job_seq.sv
// Directed bench for mvm_job_seq: table of job beats plus hand-written
// timeout, backpressure and reset sequences. A second instance with ACC_W=5
// shares the stimulus to observe saturation.
module tb_mvm_job_seq;

    localparam int unsigned ACC_W    = 8;
    localparam int unsigned ACC_W5   = 5;
    localparam int unsigned START_TO = 4;
    localparam int unsigned RUN_TO   = 31;

    logic        clk;
    logic        rst;
    logic        job_valid;
    logic [15:0] job_x;
    logic [3:0]  job_w;
    logic        job_last;
    logic        mvm_busy;
    logic [15:0] wx_result;
    logic        res_ready;

    logic        job_ready, start_mvm, res_valid, err;
    logic [15:0] x_mvm;
    logic [3:0]  w_mvm;
    logic [31:0] res_acc;
    logic [1:0]  err_code;

    logic        job_ready5, start5, res_valid5, err5;
    logic [15:0] x5;
    logic [3:0]  w5;
    logic [19:0] res_acc5;
    logic [1:0]  err_code5;

    int errors = 0;
    int checks = 0;

    mvm_job_seq #(.ACC_W(ACC_W), .START_TO(START_TO), .RUN_TO(RUN_TO)) u_dut (
        .i_clk_udc   (clk),
        .i_rst_udc   (rst),
        .i_job_valid (job_valid),
        .o_job_ready (job_ready),
        .i_job_x     (job_x),
        .i_job_w     (job_w),
        .i_job_last  (job_last),
        .o_start_mvm (start_mvm),
        .o_x_mvm     (x_mvm),
        .o_w_mvm     (w_mvm),
        .i_mvm_busy  (mvm_busy),
        .i_wx_result (wx_result),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_acc   (res_acc),
        .o_err       (err),
        .o_err_code  (err_code)
    );

    mvm_job_seq #(.ACC_W(ACC_W5), .START_TO(START_TO), .RUN_TO(RUN_TO)) u_dut5 (
        .i_clk_udc   (clk),
        .i_rst_udc   (rst),
        .i_job_valid (job_valid),
        .o_job_ready (job_ready5),
        .i_job_x     (job_x),
        .i_job_w     (job_w),
        .i_job_last  (job_last),
        .o_start_mvm (start5),
        .o_x_mvm     (x5),
        .o_w_mvm     (w5),
        .i_mvm_busy  (mvm_busy),
        .i_wx_result (wx_result),
        .o_res_valid (res_valid5),
        .i_res_ready (res_ready),
        .o_res_acc   (res_acc5),
        .o_err       (err5),
        .o_err_code  (err_code5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [3:0]  w;
        logic        last;
        logic [15:0] res;
        int          blen;
        logic [31:0] exp8;
        logic [19:0] exp5;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [15:0] p4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [31:0] a8(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [19:0] a5(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one beat from IDLE; busy is high for blen sampled cycles.
    task automatic do_beat(input vec_t v, input int idx, input bit hold);
        chk($sformatf("v%0d_ready_idle", idx), 64'(job_ready), 64'd1);
        job_valid = 1'b1;
        job_x     = v.x;
        job_w     = v.w;
        job_last  = v.last;
        @(negedge clk);
        chk($sformatf("v%0d_start", idx), 64'(start_mvm), 64'd1);
        chk($sformatf("v%0d_x_reg", idx), 64'(x_mvm), 64'(v.x));
        chk($sformatf("v%0d_w_reg", idx), 64'(w_mvm), 64'(v.w));
        chk($sformatf("v%0d_ready_busy", idx), 64'(job_ready), 64'd0);
        job_valid = 1'b0;
        job_x     = 16'hFFFF;
        job_w     = 4'hF;
        @(negedge clk);
        chk($sformatf("v%0d_start_once", idx), 64'(start_mvm), 64'd0);
        mvm_busy = 1'b1;
        repeat (v.blen) @(negedge clk);
        mvm_busy  = 1'b0;
        wx_result = v.res;
        @(negedge clk);
        @(negedge clk);
        wx_result = 16'h5A5A;
        chk($sformatf("v%0d_no_err", idx), 64'(err), 64'd0);
        chk($sformatf("v%0d_x_hold", idx), 64'(x_mvm), 64'(v.x));
        if (v.last) begin
            chk($sformatf("v%0d_valid", idx), 64'(res_valid), 64'd1);
            chk($sformatf("v%0d_ready_out", idx), 64'(job_ready), 64'd0);
            chk($sformatf("v%0d_acc8", idx), 64'(res_acc), 64'(v.exp8));
            chk($sformatf("v%0d_acc5", idx), 64'(res_acc5), 64'(v.exp5));
            if (!hold) begin
                res_ready = 1'b1;
                @(negedge clk);
                res_ready = 1'b0;
                chk($sformatf("v%0d_valid_drop", idx), 64'(res_valid), 64'd0);
                chk($sformatf("v%0d_ready_back", idx), 64'(job_ready), 64'd1);
                chk($sformatf("v%0d_acc_clr", idx), 64'(res_acc), 64'd0);
            end
        end else begin
            chk($sformatf("v%0d_no_valid", idx), 64'(res_valid), 64'd0);
            chk($sformatf("v%0d_ready_between", idx), 64'(job_ready), 64'd1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(job_ready), 64'd0);
        chk({tag, "_start"}, 64'(start_mvm), 64'd0);
        chk({tag, "_x"}, 64'(x_mvm), 64'd0);
        chk({tag, "_w"}, 64'(w_mvm), 64'd0);
        chk({tag, "_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_acc"}, 64'(res_acc), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_code"}, 64'(err_code), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        logic [31:0] held_acc;
        int          err_seen;

        vecs[0] = '{x: p4(1, 2, 3, 4), w: 4'd5, last: 1'b1, res: p4(3, -2, 7, -8), blen: 6,
                    exp8: a8(3, -2, 7, -8), exp5: a5(3, -2, 7, -8)};
        vecs[1] = '{x: p4(9, 8, 7, 6), w: 4'd1, last: 1'b0, res: p4(7, 7, 7, 7), blen: 1,
                    exp8: '0, exp5: '0};
        vecs[2] = '{x: p4(0, 1, 0, 1), w: 4'd2, last: 1'b0, res: p4(7, 7, 7, 7), blen: 3,
                    exp8: '0, exp5: '0};
        vecs[3] = '{x: p4(15, 15, 15, 15), w: 4'd3, last: 1'b1, res: p4(7, 7, 7, 7), blen: 2,
                    exp8: a8(21, 21, 21, 21), exp5: a5(15, 15, 15, 15)};
        vecs[4] = '{x: p4(4, 3, 2, 1), w: 4'd7, last: 1'b0, res: p4(7, -8, 1, -1), blen: 2,
                    exp8: '0, exp5: '0};
        vecs[5] = '{x: p4(5, 6, 7, 8), w: 4'd8, last: 1'b0, res: p4(7, -8, 1, -1), blen: 4,
                    exp8: '0, exp5: '0};
        vecs[6] = '{x: p4(10, 11, 12, 13), w: 4'd9, last: 1'b1, res: p4(7, -8, 1, -1), blen: 1,
                    exp8: a8(21, -24, 3, -3), exp5: a5(15, -16, 3, -3)};

        rst       = 1'b1;
        job_valid = 1'b0;
        job_x     = '0;
        job_w     = '0;
        job_last  = 1'b0;
        mvm_busy  = 1'b0;
        wx_result = '0;
        res_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_beat(vecs[i], i, 1'b0);
        end

        // Start timeout after a partial sum: next job must start from zero.
        do_beat(vecs[1], 10, 1'b0);
        job_valid = 1'b1;
        job_x     = p4(1, 1, 1, 1);
        job_w     = 4'd1;
        job_last  = 1'b1;
        @(negedge clk);
        chk("sto_start", 64'(start_mvm), 64'd1);
        job_valid = 1'b0;
        err_seen  = 0;
        for (int i = 0; i < int'(START_TO); i++) begin
            @(negedge clk);
            if (err) err_seen++;
        end
        chk("sto_no_early_err", 64'(err_seen), 64'd0);
        @(negedge clk);
        chk("sto_err", 64'(err), 64'd1);
        chk("sto_code", 64'(err_code), 64'(2'd1));
        chk("sto_ready", 64'(job_ready), 64'd1);
        chk("sto_acc_clr", 64'(res_acc), 64'd0);
        @(negedge clk);
        chk("sto_err_pulse", 64'(err), 64'd0);
        chk("sto_code_hold", 64'(err_code), 64'(2'd1));
        t = '{x: p4(2, 4, 6, 8), w: 4'd2, last: 1'b1, res: p4(1, 2, 3, 4), blen: 2,
              exp8: a8(1, 2, 3, 4), exp5: a5(1, 2, 3, 4)};
        do_beat(t, 11, 1'b0);

        // Run timeout: busy never falls.
        job_valid = 1'b1;
        job_x     = p4(3, 3, 3, 3);
        job_last  = 1'b0;
        @(negedge clk);
        job_valid = 1'b0;
        @(negedge clk);
        mvm_busy = 1'b1;
        err_seen = 0;
        for (int i = 0; i < int'(RUN_TO); i++) begin
            @(negedge clk);
            if (err) err_seen++;
        end
        chk("rto_no_early_err", 64'(err_seen), 64'd0);
        @(negedge clk);
        chk("rto_err", 64'(err), 64'd1);
        chk("rto_code", 64'(err_code), 64'(2'd2));
        chk("rto_ready", 64'(job_ready), 64'd1);
        mvm_busy = 1'b0;
        @(negedge clk);
        chk("rto_err_pulse", 64'(err), 64'd0);
        chk("rto_code_hold", 64'(err_code), 64'(2'd2));

        // Backpressure in OUT with a competing beat, then reset mid-OUT.
        t = '{x: p4(6, 5, 4, 3), w: 4'd4, last: 1'b1, res: p4(5, -5, 1, 0), blen: 3,
              exp8: a8(5, -5, 1, 0), exp5: a5(5, -5, 1, 0)};
        do_beat(t, 12, 1'b1);
        held_acc  = res_acc;
        job_valid = 1'b1;
        job_x     = p4(2, 2, 2, 2);
        job_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", i), 64'(res_valid), 64'd1);
            chk($sformatf("bp%0d_acc", i), 64'(res_acc), 64'(a8(5, -5, 1, 0)));
            chk($sformatf("bp%0d_stable", i), 64'(res_acc), 64'(held_acc));
            chk($sformatf("bp%0d_ready", i), 64'(job_ready), 64'd0);
            chk($sformatf("bp%0d_no_start", i), 64'(start_mvm), 64'd0);
        end
        chk("bp_x_hold", 64'(x_mvm), 64'(p4(6, 5, 4, 3)));
        job_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_out");
        chk("rst_out_acc5", 64'(res_acc5), 64'd0);
        rst = 1'b0;
        err_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res_valid) err_seen++;
        end
        chk("rst_no_result", 64'(err_seen), 64'd0);
        chk("rst_recover_ready", 64'(job_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mvm_job_seq.md
Name: mvm_job_seq

Overview:
- Sequencer for the stochastic 4-lane MVM engine (4 x 4-bit BN inputs, one 4-bit weight per pass, up/down-counter results).
- Accepts job beats (x vector, weight, last flag) over a valid/ready handshake.
- For each beat: pulses the engine start, tracks its busy flag, captures the four 4-bit signed results and accumulates them into wider signed sums.
- On the last beat of a job, presents the sums downstream with valid/ready; aborts with an error pulse if the engine hangs.

Parameters:
ACC_W, 8, accumulator width per lane (signed, two's complement)
START_TO, 4, max cycles from start pulse to busy rising before abort
RUN_TO, 31, max cycles busy may stay high before abort

Ports:
i_clk_udc  in  1  clock
i_rst_udc  in  1  reset, asynchronous, active-high
i_job_valid  in  1  job beat valid
o_job_ready  out  1  sequencer can accept a beat
i_job_x  in  4x4  BN inputs for the 4 lanes
i_job_w  in  4  weight for this pass
i_job_last  in  1  final beat of the job
o_start_mvm  out  1  one-cycle start pulse to engine
o_x_mvm  out  4x4  registered x to engine
o_w_mvm  out  4  registered weight to engine
i_mvm_busy  in  1  engine generating
i_wx_result  in  4x4  engine lane results, 4-bit signed
o_res_valid  out  1  accumulated result valid
i_res_ready  in  1  downstream accepts result
o_res_acc  out  4xACC_W  signed accumulated lane sums
o_err  out  1  one-cycle abort pulse
o_err_code  out  2  0 none, 1 start timeout, 2 run timeout; held until next error or reset

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; accumulators, timers, x/w registers 0.
- States: IDLE, LAUNCH, WAIT_BUSY, RUN, CAPTURE, OUT.
- IDLE:
  - o_job_ready=1.
  - On valid&&ready: latch x, w, last into registers driving o_x_mvm/o_w_mvm; go LAUNCH.
- LAUNCH: o_start_mvm=1 for exactly this cycle; clear timer; go WAIT_BUSY. Accept-to-start latency is 1 cycle.
- WAIT_BUSY:
  - i_mvm_busy=1: go RUN, clear timer.
  - Otherwise increment timer; on timer==START_TO: o_err=1, code=1, clear accumulators, go IDLE.
- RUN:
  - i_mvm_busy=0: go CAPTURE.
  - Otherwise increment timer; on timer==RUN_TO: abort as above with code=2.
- CAPTURE (one cycle):
  - Per lane: acc += sign_extend(i_wx_result[k]).
  - Saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; never wrap.
  - If last: go OUT; else go IDLE.
- OUT:
  - o_res_valid=1; o_res_acc stable while valid.
  - On i_res_ready: clear accumulators, go IDLE.
  - o_job_ready=0 throughout.
- Registers o_x_mvm/o_w_mvm hold their values from accept until the next accept.
- Single-beat job (last=1 on first beat): result = sign-extended engine result.
- Reset during RUN or OUT: result is discarded; no o_res_valid after reset.
- o_job_ready is 0 in all states except IDLE. A beat presented during a job is held by the upstream valid/ready contract and is not dropped.
- Busy already high in the LAUNCH cycle: ignored. Only WAIT_BUSY samples the rising busy.
- Busy high for 1 cycle only: valid. The RUN→CAPTURE transition occurs on the first low sample.
- After an abort, the next accepted beat starts a new job from zero sums.

Decomposition:
- Shared package mvm_pkg:
  - State enum mvm_seq_state_t.
  - Error code constants ERR_NONE/ERR_START_TO/ERR_RUN_TO.
  - Lane count constant MVM_LANES=4; BN width constant BN_W=4.
- One sub-module, mvm_sat_acc: single-lane signed saturating accumulator with clear and add-enable. Instantiated MVM_LANES times.

Test Plan:
- Single beat x={1,2,3,4}, w=5, last=1; engine model busy 6 cycles, returns {3,-2,7,-8} -> o_start_mvm pulses 1 cycle after accept; o_res_valid with acc {3,-2,7,-8}; o_err never set.
- Three beats returning {7,7,7,7} each, last on beat 3, ACC_W=8 -> acc {21,21,21,21}; o_res_valid only after beat 3; o_job_ready=1 between beats.
- Saturation: ACC_W=5, 3 beats of lane0 result 7 -> lane0 acc=15 (max), not wrapped; 3 beats of -8 -> -16.
- Engine never asserts busy -> o_err pulses at START_TO cycles after LAUNCH, o_err_code=1, back to IDLE with o_job_ready=1; next job's sum starts from 0.
- Busy stuck high -> o_err with code=2 after RUN_TO cycles in RUN.
- i_res_ready held low 10 cycles -> o_res_valid and o_res_acc stable, o_job_ready=0. Then assert reset mid-OUT -> all outputs 0 next cycle; no result emitted.
